// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, runs the CPU with a timeout, then dumps a data-memory window
module prog_loader #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 65535,
  parameter int RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ins_we,
  output logic [ADDR_W-1:0] ins_addr,
  output logic [DATA_W-1:0] ins_wdata,
  output logic              cpu_rst,
  input  logic              cpu_done,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic [31:0]       cycle_count
);
  localparam int PW = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DUMP_RD, DUMP_WAIT, FIN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, load_len_q, load_len_d, dump_len_q, dump_len_d, ptr_inc;
  logic [ADDR_W-1:0] dump_base_q, dump_base_d, ins_addr_q, ins_addr_d;
  logic [DATA_W-1:0] ins_wdata_q, ins_wdata_d, m_data_q, m_data_d;
  logic ins_we_q, ins_we_d, m_valid_q, m_valid_d, timeout_err_q, timeout_err_d, cpu_rst_q;
  logic [31:0] cycle_count_q, cycle_count_d;
  assign ptr_inc = ptr_q + PW'(1);
  assign s_ready = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign finished = state_q == FIN;
  assign dm_addr = dump_base_q + ptr_q[ADDR_W-1:0];
  assign ins_we = ins_we_q;
  assign ins_addr = ins_addr_q;
  assign ins_wdata = ins_wdata_q;
  assign cpu_rst = cpu_rst_q;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign timeout_err = timeout_err_q;
  assign cycle_count = cycle_count_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    load_len_d = load_len_q;
    dump_base_d = dump_base_q;
    dump_len_d = dump_len_q;
    ins_we_d = 1'b0;
    ins_addr_d = ins_addr_q;
    ins_wdata_d = ins_wdata_q;
    m_valid_d = m_valid_q;
    m_data_d = m_data_q;
    timeout_err_d = timeout_err_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      IDLE: if (start) begin
        load_len_d = load_len;
        dump_base_d = dump_base;
        dump_len_d = dump_len;
        cycle_count_d = '0;
        timeout_err_d = 1'b0;
        ptr_d = '0;
        state_d = load_len == '0 ? HOLD : LOAD;
      end
      LOAD: if (s_valid) begin
        ins_we_d = 1'b1;
        ins_addr_d = ptr_q[ADDR_W-1:0];
        ins_wdata_d = s_data;
        ptr_d = ptr_inc == load_len_q ? '0 : ptr_inc;
        state_d = ptr_inc == load_len_q ? HOLD : LOAD;
      end
      HOLD: begin
        ptr_d = ptr_inc >= PW'(RST_HOLD) ? '0 : ptr_inc;
        state_d = ptr_inc >= PW'(RST_HOLD) ? RUN : HOLD;
      end
      RUN: begin
        cycle_count_d = cycle_count_q + 32'd1;
        if (cpu_done) state_d = DUMP_RD;
        else if (cycle_count_q == 32'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d = DUMP_RD;
        end
      end
      DUMP_RD: if (dump_len_q == '0) state_d = FIN;
      else begin
        m_data_d = dm_rdata;
        m_valid_d = 1'b1;
        state_d = DUMP_WAIT;
      end
      DUMP_WAIT: if (m_ready) begin
        m_valid_d = 1'b0;
        ptr_d = ptr_inc;
        state_d = ptr_inc == dump_len_q ? FIN : DUMP_RD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      load_len_q <= '0;
      dump_base_q <= '0;
      dump_len_q <= '0;
      ins_we_q <= 1'b0;
      ins_addr_q <= '0;
      ins_wdata_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      timeout_err_q <= 1'b0;
      cycle_count_q <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      load_len_q <= load_len_d;
      dump_base_q <= dump_base_d;
      dump_len_q <= dump_len_d;
      ins_we_q <= ins_we_d;
      ins_addr_q <= ins_addr_d;
      ins_wdata_q <= ins_wdata_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      timeout_err_q <= timeout_err_d;
      cycle_count_q <= cycle_count_d;
      cpu_rst_q <= state_q != RUN;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side counterpart of the processor's instruction-load and data-memory interfaces.
- Streams a program into instruction memory while holding the CPU in reset, then releases the CPU and counts cycles until the CPU raises done or a timeout expires.
- Finally reads back a window of data memory and streams it out.
- Sits between a host link (UART/testbench stream) and the processor top.

Parameters:
- ADDR_W, 10, word-address width of instruction and data memories
- DATA_W, 32, memory word width
- TIMEOUT, 65535, max RUN cycles before abort
- RST_HOLD, 2, cycles cpu_rst stays high after load before release

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a session (ignored while busy=1)
- load_len  in  ADDR_W+1  number of instruction words to load, 0..1024
- dump_base  in  ADDR_W  first data-memory word to dump
- dump_len  in  ADDR_W+1  number of data words to dump, 0..1024
- s_valid  in  1  instruction stream valid
- s_data  in  DATA_W  instruction word
- s_ready  out  1  loader accepts a word
- ins_we  out  1  instruction-memory write enable to processor
- ins_addr  out  ADDR_W  instruction-memory write address
- ins_wdata  out  DATA_W  instruction-memory write data
- cpu_rst  out  1  reset driven into processor
- cpu_done  in  1  processor done flag
- dm_addr  out  ADDR_W  data-memory read-port address
- dm_rdata  in  DATA_W  data-memory read data (asynchronous, same cycle)
- m_valid  out  1  dump stream valid
- m_data  out  DATA_W  dump word
- m_ready  in  1  dump stream ready
- busy  out  1  session in progress
- finished  out  1  one-cycle pulse at session end
- timeout_err  out  1  sticky: last session hit TIMEOUT
- cycle_count  out  32  RUN cycles of last session

Behaviour:
- Reset values:
  - cpu_rst=1; all other outputs 0.
  - FSM=IDLE; internal pointers 0.
  - Reset mid-session aborts immediately to IDLE.
- States: IDLE, LOAD, HOLD, RUN, DUMP_RD, DUMP_WAIT, FIN.
- cpu_rst:
  - =1 in IDLE, LOAD, HOLD, DUMP_RD, DUMP_WAIT and FIN.
  - =0 only in RUN.
  - Registered: changes the cycle after the state change.
- IDLE:
  - On start, latch load_len, dump_base and dump_len.
  - Clear cycle_count and timeout_err; ptr=0; busy=1.
  - Go LOAD; if load_len=0, go HOLD instead.
- LOAD:
  - s_ready=1 (combinational from state).
  - On s_valid&&s_ready, next cycle ins_we=1, ins_addr=ptr, ins_wdata=s_data; ptr++.
  - ins_we is a one-cycle pulse per word.
  - When the accepted word is the load_len-th, s_ready drops the following cycle and FSM goes HOLD.
  - s_valid=0 simply stalls the load; no timeout applies in LOAD.
- HOLD: count RST_HOLD cycles, then go RUN.
- RUN:
  - cycle_count increments every cycle in RUN.
  - If cpu_done=1, go DUMP_RD; cycle_count freezes at that value.
  - Else if cycle_count reaches TIMEOUT-1, set timeout_err=1 and go DUMP_RD (the dump still occurs for debug).
  - If cpu_done and the timeout coincide, done wins and timeout_err stays 0.
- DUMP_RD:
  - If dump_len=0, go FIN.
  - Otherwise dm_addr=dump_base+idx, wrapping mod 2^ADDR_W.
  - m_data<=dm_rdata, m_valid<=1; go DUMP_WAIT.
- DUMP_WAIT:
  - m_valid and m_data are held stable until m_ready.
  - On m_valid&&m_ready: m_valid<=0, idx++.
  - Then go FIN if idx was dump_len-1, else go DUMP_RD.
  - Throughput is 1 word per 2 cycles minimum.
- FIN: finished=1 for one cycle; busy<=0; go IDLE.
- Output hold: timeout_err and cycle_count hold until the next start.
- Address wrap: load pointer wraps at 1024, so load_len=1024 fills the whole memory.

Test Plan:
- Load/run/dump:
  - Stimulus: start with load_len=3, words 0x20010005, 0x20020007, 0xFC000000 (halt); cpu_done asserts on RUN cycle 3; dump_base=0, dump_len=2, m_ready=1.
  - Response: three ins_we pulses at addr 0,1,2 with matching data; cpu_rst low exactly during RUN; cycle_count=3; two m_valid beats of dm_rdata[0], dm_rdata[1]; finished pulse; timeout_err=0.
- Stream stalls:
  - Stimulus: s_valid toggling 1,0,0,1,1 for load_len=3.
  - Response: ins_we only on accepted words; addresses contiguous 0..2; no extra writes.
- Backpressure:
  - Stimulus: dump_len=3, dump_base=1022, m_ready low for 4 cycles on the first beat.
  - Response: m_data stable while stalled; words from addresses 1022, 1023, 0 (wrap).
- Timeout:
  - Stimulus: TIMEOUT=16, cpu_done never asserts.
  - Response: timeout_err=1; cycle_count=16; cpu_rst reasserted; dump proceeds; finished pulses.
- Zero lengths and ignored start:
  - Stimulus: load_len=0, dump_len=0; also a second start pulse while busy.
  - Response: goes HOLD→RUN directly; no m_valid beats; finished pulses; second start ignored.
- Reset mid-RUN:
  - Stimulus: assert rst during RUN.
  - Response: next cycle FSM=IDLE, cpu_rst=1, busy=0, m_valid=0, ins_we=0.
